// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and sizing helpers for the FIFO push arbiter.
package fifo_arb_pkg;
    localparam int N_REQ_DEF  = 4;
    localparam int DATA_W_DEF = 8;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic {IDLE, LOCKED} arb_state_e;

    function automatic int grant_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/fifo_push_arbiter_rr_pick.sv
// rr_pick: round-robin winner search starting at ptr, wrapping at N.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N = N_REQ_DEF,
    parameter int W = grant_w(N)
) (
    input  logic [N-1:0] valid,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] winner,
    output logic         any
);
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [W-1:0]   idx;
    logic [W:0]     sum;

    // Rotate so ptr lands at bit 0, take the lowest set bit, then rotate back.
    always_comb begin
        dbl = {valid, valid};
        rot = N'(dbl >> ptr);
        idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (rot[i]) idx = W'(i);
        sum = {1'b0, idx} + {1'b0, ptr};
        winner = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : W'(sum);
        any = |valid;
    end
endmodule

// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter: packet-locking round-robin arbiter feeding one FIFO push port.
module fifo_push_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ  = N_REQ_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    localparam int GW    = grant_w(N_REQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid_i,
    input  logic [N_REQ*DATA_W-1:0] req_data_i,
    input  logic [N_REQ-1:0]        req_last_i,
    output logic [N_REQ-1:0]        req_ready_o,
    output logic                    fifo_push_o,
    output logic [DATA_W-1:0]       fifo_push_data_o,
    input  logic                    fifo_full_i,
    output logic [GW-1:0]           grant_id_o,
    output logic                    busy_o,
    output logic [CNT_W-1:0]        pkt_count_o
);
    arb_state_e        state;
    logic [GW-1:0]     grant_q;
    logic [GW-1:0]     ptr;
    logic [CNT_W-1:0]  pkt_count;
    logic [GW-1:0]     winner;
    logic              any;
    logic              locked;
    logic              done;
    logic [DATA_W-1:0] words [N_REQ];

    rr_pick #(.N(N_REQ), .W(GW)) u_pick (
        .valid  (req_valid_i),
        .ptr    (ptr),
        .winner (winner),
        .any    (any)
    );

    always_comb begin
        for (int k = 0; k < N_REQ; k++)
            words[k] = req_data_i[k*DATA_W +: DATA_W];
        locked           = (state == LOCKED);
        req_ready_o      = (locked && !fifo_full_i) ? N_REQ'(1) << grant_q : '0;
        fifo_push_o      = locked && !fifo_full_i && req_valid_i[grant_q];
        fifo_push_data_o = locked ? words[grant_q] : '0;
        done             = fifo_push_o && req_last_i[grant_q];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            grant_q   <= '0;
            ptr       <= '0;
            pkt_count <= '0;
        end else if (state == IDLE) begin
            if (any) begin
                grant_q <= winner;
                state   <= LOCKED;
            end
        end else if (done) begin
            state     <= IDLE;
            ptr       <= (grant_q == GW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
            pkt_count <= (&pkt_count) ? pkt_count : pkt_count + 1'b1;
        end
    end

    assign grant_id_o  = grant_q;
    assign busy_o      = locked;
    assign pkt_count_o = pkt_count;
endmodule

// File: tb/tb_fifo_push_arbiter.sv
// tb_fifo_push_arbiter: directed checks of arbitration order, locking, full stalls and saturation.
module tb_fifo_push_arbiter;
    logic        clk = 0;
    logic        reset = 1;
    logic [3:0]  valid = '0;
    logic [31:0] data = '0;
    logic [3:0]  last = '0;
    logic [3:0]  ready;
    logic        push;
    logic [7:0]  push_data;
    logic        full = 0;
    logic [1:0]  grant;
    logic        busy;
    logic [15:0] count;
    int checks = 0;
    int errors = 0;

    fifo_push_arbiter #(.N_REQ(4), .DATA_W(8), .CNT_W(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid_i      (valid),
        .req_data_i       (data),
        .req_last_i       (last),
        .req_ready_o      (ready),
        .fifo_push_o      (push),
        .fifo_push_data_o (push_data),
        .fifo_full_i      (full),
        .grant_id_o       (grant),
        .busy_o           (busy),
        .pkt_count_o      (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int k, input logic v, input logic [7:0] d, input logic l);
        valid[k] = v;
        data[k*8 +: 8] = d;
        last[k] = l;
    endtask

    task automatic next;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1;
        valid = '0;
        data = '0;
        last = '0;
        full = 0;
        next;
        reset = 0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ready"}, 32'(ready), 0);
        check({tag, "_push"}, 32'(push), 0);
        check({tag, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        logic [7:0] exp_d [15] = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h10, 8'h11, 8'h00, 8'h20,
                                   8'h21, 8'h00, 8'h30, 8'h31, 8'h00, 8'h00, 8'h01};
        logic       exp_p [15] = '{0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1};
        int         exp_g [15] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0, 0};
        logic       w [4];

        // Reset values
        next;
        check_idle("rst");
        check("rst_data", 32'(push_data), 0);
        check("rst_grant", 32'(grant), 0);
        check("rst_count", 32'(count), 0);
        reset = 0;

        // Single 3-word packet from req0
        drive(0, 1, 8'hA1, 0);
        #1 check_idle("t1_arb");
        next;
        check("t1_ready0", 32'(ready), 32'h1);
        check("t1_push0", 32'(push), 1);
        check("t1_data0", 32'(push_data), 32'hA1);
        check("t1_busy", 32'(busy), 1);
        next;
        drive(0, 1, 8'hA2, 0);
        #1 check("t1_push1", 32'(push), 1);
        check("t1_data1", 32'(push_data), 32'hA2);
        next;
        drive(0, 1, 8'hA3, 1);
        #1 check("t1_push2", 32'(push), 1);
        check("t1_data2", 32'(push_data), 32'hA3);
        next;
        drive(0, 0, 8'h00, 0);
        #1 check_idle("t1_end");
        check("t1_count", 32'(count), 1);
        check("t1_grant_held", 32'(grant), 0);

        // All four requesters stream 2-word packets
        do_reset;
        for (int k = 0; k < 4; k++) w[k] = 0;
        for (int c = 0; c < 15; c++) begin
            for (int k = 0; k < 4; k++) drive(k, 1, 8'(16 * k + int'(w[k])), w[k]);
            #1;
            check($sformatf("t2_push_c%0d", c), 32'(push), 32'(exp_p[c]));
            check($sformatf("t2_busy_c%0d", c), 32'(busy), 32'(exp_p[c]));
            check($sformatf("t2_grant_c%0d", c), 32'(grant), 32'(exp_g[c]));
            if (exp_p[c]) check($sformatf("t2_data_c%0d", c), 32'(push_data), 32'(exp_d[c]));
            for (int k = 0; k < 4; k++) if (valid[k] && ready[k]) w[k] = ~w[k];
            next;
        end

        // FIFO full for three cycles mid-packet
        do_reset;
        drive(0, 1, 8'hB1, 0);
        #1 check("t3_arb_push", 32'(push), 0);
        next;
        check("t3_push_b1", 32'(push_data), 32'hB1);
        check("t3_push_b1v", 32'(push), 1);
        next;
        drive(0, 1, 8'hB2, 0);
        full = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("t3_full_push%0d", i), 32'(push), 0);
            check($sformatf("t3_full_ready%0d", i), 32'(ready), 0);
            check($sformatf("t3_full_busy%0d", i), 32'(busy), 1);
            check($sformatf("t3_full_grant%0d", i), 32'(grant), 0);
            next;
        end
        full = 0;
        #1 check("t3_push_b2v", 32'(push), 1);
        check("t3_push_b2", 32'(push_data), 32'hB2);
        next;
        drive(0, 1, 8'hB3, 1);
        #1 check("t3_push_b3", 32'(push_data), 32'hB3);
        next;
        drive(0, 0, 8'h00, 0);
        #1 check_idle("t3_end");
        check("t3_count", 32'(count), 1);

        // Granted requester stalls while another waits
        do_reset;
        drive(2, 1, 8'hC0, 0);
        #1 check("t4_arb_push", 32'(push), 0);
        next;
        drive(1, 1, 8'hD0, 1);
        #1 check("t4_grant", 32'(grant), 2);
        check("t4_ready", 32'(ready), 32'h4);
        check("t4_push_c0", 32'(push_data), 32'hC0);
        next;
        drive(2, 0, 8'hC1, 0);
        for (int i = 0; i < 2; i++) begin
            #1;
            check($sformatf("t4_stall_grant%0d", i), 32'(grant), 2);
            check($sformatf("t4_stall_push%0d", i), 32'(push), 0);
            check($sformatf("t4_stall_busy%0d", i), 32'(busy), 1);
            next;
        end
        drive(2, 1, 8'hC1, 1);
        #1 check("t4_push_c1v", 32'(push), 1);
        check("t4_push_c1", 32'(push_data), 32'hC1);
        next;
        drive(2, 0, 8'h00, 0);
        #1 check_idle("t4_bubble");
        check("t4_bubble_grant", 32'(grant), 2);
        next;
        check("t4_grant1", 32'(grant), 1);
        check("t4_ready1", 32'(ready), 32'h2);
        check("t4_push_d0", 32'(push_data), 32'hD0);
        next;
        drive(1, 0, 8'h00, 0);
        #1 check("t4_count", 32'(count), 2);

        // Asynchronous reset in the middle of a packet
        do_reset;
        drive(3, 1, 8'hE0, 0);
        next;
        check("t5_grant3", 32'(grant), 3);
        check("t5_push_e0", 32'(push_data), 32'hE0);
        next;
        drive(3, 1, 8'hE1, 0);
        #1 check("t5_push_e1", 32'(push_data), 32'hE1);
        #1 reset = 1;
        #1 check_idle("t5_async");
        check("t5_async_data", 32'(push_data), 0);
        check("t5_async_grant", 32'(grant), 0);
        next;
        reset = 0;
        drive(1, 1, 8'hF0, 1);
        next;
        check("t5_restart_grant", 32'(grant), 1);
        check("t5_restart_data", 32'(push_data), 32'hF0);
        next;
        valid = '0;
        last = '0;
        #1 check("t5_count", 32'(count), 1);

        // Counter saturation
        force dut.pkt_count = 16'hFFFE;
        next;
        release dut.pkt_count;
        #1 check("t6_preload", 32'(count), 32'hFFFE);
        drive(2, 1, 8'h5A, 1);
        next;
        check("t6_push", 32'(push), 1);
        next;
        #1 check("t6_count_max", 32'(count), 32'hFFFF);
        next;
        next;
        drive(2, 0, 8'h00, 0);
        #1 check("t6_count_sat", 32'(count), 32'hFFFF);
        check_idle("t6_end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_push_arbiter.md
Name: fifo_push_arbiter

Overview:
- Round-robin, packet-locking arbiter that shares one synchronous FIFO push port between N_REQ producers.
- Each producer offers words with a valid/ready handshake, and a packet is marked by a last flag.
- The arbiter grants one producer at a time and holds the grant until that producer's last word is written.
- Sits directly in front of the team's parameterized sync FIFO and drives its push/push_data inputs from the FIFO's full flag.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- DATA_W, 8, data width in bits; must match the FIFO's data width.
- CNT_W, 16, width of the completed-packet counter.

Ports:
- clk  input  1  clock.
- reset  input  1  reset, asynchronous, active-high.
- req_valid_i  input  N_REQ  per-requester word valid.
- req_data_i  input  N_REQ*DATA_W  packed data; requester k occupies bits [k*DATA_W +: DATA_W].
- req_last_i  input  N_REQ  per-requester last-word-of-packet flag, qualified by valid.
- req_ready_o  output  N_REQ  per-requester ready; a transfer occurs when valid and ready are both high.
- fifo_push_o  output  1  push strobe to the FIFO.
- fifo_push_data_o  output  DATA_W  data to the FIFO.
- fifo_full_i  input  1  FIFO full flag.
- grant_id_o  output  $clog2(N_REQ)  index of the currently granted requester.
- busy_o  output  1  high while a grant is held (LOCKED state).
- pkt_count_o  output  CNT_W  number of completed packets; saturates at all-ones.

Behaviour:
- Reset values: state IDLE; grant_q 0; priority pointer 0; pkt_count 0.
  - All req_ready_o 0, fifo_push_o 0, busy_o 0.
  - fifo_push_data_o and grant_id_o are 0.
- FSM has two states, IDLE and LOCKED.
- IDLE:
  - No ready is asserted and no push occurs.
  - If any req_valid_i bit is high, the winner is the first set bit found searching upward from the pointer, with wrap-around.
  - Next cycle: grant_q is set to the winner and the state becomes LOCKED.
  - If no valid bit is high, the FSM stays in IDLE.
- LOCKED with grant g:
  - req_ready_o[g] = !fifo_full_i; all other ready bits are 0.
  - fifo_push_o = req_valid_i[g] & !fifo_full_i.
  - fifo_push_data_o is driven by requester g's data slice.
  - This path is combinational from fifo_full_i and req_valid_i.
- A transfer with req_last_i[g] set ends the packet:
  - Next cycle the state is IDLE.
  - The pointer becomes (g+1) mod N_REQ.
  - pkt_count increments, saturating.
- Latency:
  - 1 cycle from valid to the first ready (arbitration cycle).
  - 1 bubble cycle between packets, so peak throughput is L words per L+1 cycles.
- Full: while fifo_full_i is high there is no transfer, the grant is held and the state is unchanged. Data must not be dropped.
- If the granted requester drops valid mid-packet, the grant is held with no push; other requesters keep waiting.
- A single-word packet (valid with last) completes in one LOCKED cycle.
- The arbiter never pushes while fifo_full_i is high, so overflow is impossible from this block.
- Reset asserted mid-packet immediately returns every register to its reset value. The partial packet already in the FIFO is the consumer's responsibility.
- grant_id_o = grant_q; it is held after a packet ends and updated on the next grant.
- N_REQ not a power of two: the pointer wraps at N_REQ, not at 2^width.

Decomposition:
- Package fifo_arb_pkg:
  - localparam GRANT_W function of N_REQ.
  - Enum arb_state_e {IDLE, LOCKED}.
  - Default width constants.
- Sub-module rr_pick:
  - Combinational function of (valid vector, pointer).
  - Outputs the winner index and an any-valid flag.
  - Implemented as a rotate, priority-encode, un-rotate sequence.
- The top level holds the FSM, the data mux and the counter.

Test Plan:
- Reset, then req0 sends a 3-word packet (0xA1, 0xA2, 0xA3, last on 0xA3) with full=0.
  - Ready is asserted one cycle after valid.
  - Three consecutive pushes of 0xA1, 0xA2, 0xA3.
  - busy drops afterwards and pkt_count=1.
- All 4 requesters hold 2-word packets continuously.
  - Grant order is 0,1,2,3,0.
  - No interleaving of words between packets.
  - One IDLE bubble between packets.
- Mid-packet, fifo_full_i is held high for 3 cycles.
  - fifo_push_o=0 and req_ready_o=0 during those cycles; grant is unchanged.
  - The remaining words are pushed in order after full drops.
- req2 drops valid for 2 cycles mid-packet while req1 is valid.
  - Grant stays 2 with no push.
  - req1 is granted only after req2's last word.
- Assert reset during word 2 of a 4-word packet.
  - All outputs return to their reset values asynchronously.
  - After release, arbitration restarts from pointer 0.
- Preload pkt_count near saturation (65535 packets via force or a long run), then complete one more packet.
  - pkt_count stays at 0xFFFF.
